core_perf_counters: RTL
=======================

# core_perf_counters

Per-core performance-counter block for the Radiance SIMT core. It accumulates retire, cycle, decode, eligibility, issue and per-warp hazard-stall events from the core pipeline, and detects kernel completion through a run/drain/done state machine. Its registered outputs feed the simulation profiler bridge directly: the scalar counters, the packed per-warp vectors and the `finished` flag.

## Interface
Parameters:
- NUM_WARPS, 8, number of hardware warps
- COUNTER_WIDTH, 64, width of every counter
- RETIRE_W, 4, width of per-cycle retire count
- DRAIN_CYCLES, 16, consecutive all-idle cycles required before finish; must be ≥2

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- clear  in  1  synchronous soft clear; same effect as reset, lower priority
- warpActive  in  NUM_WARPS  per-warp active mask
- retireCount  in  RETIRE_W  instructions retired this cycle
- decodeValid  in  NUM_WARPS  per-warp decode-buffer valid
- eligible  in  1  scheduler has ≥1 eligible warp this cycle
- issueFire  in  1  an instruction issued this cycle
- stallWAW  in  NUM_WARPS  per-warp WAW scoreboard stall
- stallWAR  in  NUM_WARPS  per-warp WAR scoreboard stall
- finished  out  1  kernel complete; counters frozen
- instRetired, cycles, cyclesDecoded, cyclesEligible, cyclesIssued  out  COUNTER_WIDTH each  scalar counters
- perWarp_cyclesDecoded, perWarp_stallsWAW, perWarp_stallsWAR  out  NUM_WARPS*COUNTER_WIDTH each  packed; warp i at bits [i*COUNTER_WIDTH +: COUNTER_WIDTH]

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset and clear both go to IDLE.
- IDLE:
  - When `|warpActive` is high, go to RUN. Otherwise stay.
- RUN:
  - When `warpActive == 0`, go to DRAIN and load `drainCnt <= 1`. Otherwise stay.
- DRAIN:
  - If any warp is active, go to RUN.
  - Otherwise, if `drainCnt == DRAIN_CYCLES-1`, go to DONE.
  - Otherwise, `drainCnt++`.
- DONE:
  - Held until reset or clear.
- Count enable `en = (state==RUN) | (state==DRAIN) | (state==IDLE & |warpActive)`. The first active cycle is counted.
- Updates when `en` is high:
  - `cycles += 1`
  - `instRetired += retireCount`
  - `cyclesDecoded += |decodeValid`
  - `cyclesEligible += eligible`
  - `cyclesIssued += issueFire`
  - for each warp i: `perWarp_cyclesDecoded[i] += decodeValid[i]`, `perWarp_stallsWAW[i] += stallWAW[i]`, `perWarp_stallsWAR[i] += stallWAR[i]`
- All additions saturate at 2^COUNTER_WIDTH-1; counters never wrap.
- DONE: every counter holds its value and all inputs are ignored.
- `finished = (state==DONE)`, registered.
- Reset has priority over clear. Clear has priority over all counting in the same cycle.

## Timing
- Reset value of every output is 0, including `finished`.
- Reset or clear asserted in cycle t: all outputs are 0 from cycle t+1.
- An event in cycle t is reflected on the outputs in cycle t+1. There is no combinational path from input to output.
- Every all-idle cycle after RUN is counted in `cycles`, DRAIN_CYCLES of them in total. `finished` rises on the cycle after the last one.
- Reactivation in DRAIN: that cycle is counted, the state returns to RUN, and `drainCnt` restarts at the next idle period.
- Reset or clear mid-DRAIN or in DONE: return to IDLE with all counters zeroed.

## Test plan
- Reset, then warpActive=0 for 50 cycles -> all outputs stay 0; finished=0.
- warpActive=8'h01 for 10 cycles (issueFire=1, retireCount=2 each cycle), then 0 -> cycles=26, cyclesIssued=10, instRetired=20; finished rises 26 cycles after the first active cycle.
- Idle gap of 15 cycles (DRAIN_CYCLES=16) then warp 3 active again -> finished stays 0; cycles keeps counting through the gap.
- decodeValid=8'h05 for 4 cycles, stallWAW[2]=1 for 3 cycles, stallWAR[7]=1 for 1 cycle, all during RUN -> cyclesDecoded=4; perWarp_cyclesDecoded word 0 = 4, word 2 = 4, others 0; perWarp_stallsWAW word 2 = 3; perWarp_stallsWAR word 7 = 1.
- COUNTER_WIDTH=4, retireCount=15 for 3 active cycles -> instRetired saturates at 15 and does not wrap.
- Pulse clear in DONE, then run a new burst -> finished=0 and counters at 0 the cycle after clear; the new burst counts from 0.

Source files
------------

// File: rtl/core_perf_counters.sv
// Per-core performance counters for the Radiance SIMT core.
// Saturating event counters gated by a run/drain/done kernel-completion FSM.
module core_perf_counters #(
  parameter int unsigned NUM_WARPS     = 8,
  parameter int unsigned COUNTER_WIDTH = 64,
  parameter int unsigned RETIRE_W      = 4,
  parameter int unsigned DRAIN_CYCLES  = 16
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               clear,
  input  logic [NUM_WARPS-1:0]               warpActive,
  input  logic [RETIRE_W-1:0]                retireCount,
  input  logic [NUM_WARPS-1:0]               decodeValid,
  input  logic                               eligible,
  input  logic                               issueFire,
  input  logic [NUM_WARPS-1:0]               stallWAW,
  input  logic [NUM_WARPS-1:0]               stallWAR,
  output logic                               finished,
  output logic [COUNTER_WIDTH-1:0]           instRetired,
  output logic [COUNTER_WIDTH-1:0]           cycles,
  output logic [COUNTER_WIDTH-1:0]           cyclesDecoded,
  output logic [COUNTER_WIDTH-1:0]           cyclesEligible,
  output logic [COUNTER_WIDTH-1:0]           cyclesIssued,
  output logic [NUM_WARPS*COUNTER_WIDTH-1:0] perWarp_cyclesDecoded,
  output logic [NUM_WARPS*COUNTER_WIDTH-1:0] perWarp_stallsWAW,
  output logic [NUM_WARPS*COUNTER_WIDTH-1:0] perWarp_stallsWAR
);

  localparam int unsigned SUM_W  = ((COUNTER_WIDTH > RETIRE_W) ? COUNTER_WIDTH : RETIRE_W) + 1;
  localparam int unsigned DCNT_W = $clog2(DRAIN_CYCLES);
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [DCNT_W-1:0]        DRAIN_LAST = DCNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state;
  logic [DCNT_W-1:0]   drain_cnt;
  logic                any_active;
  logic                count_en;

  assign any_active = |warpActive;
  assign count_en   = (state == RUN) || (state == DRAIN) || ((state == IDLE) && any_active);

  // Add with clamp at all-ones; the extra sum bit catches the carry out.
  function automatic logic [COUNTER_WIDTH-1:0] sat_add(
    input logic [COUNTER_WIDTH-1:0] a,
    input logic [RETIRE_W-1:0]      b
  );
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(b);
    if (sum > SUM_W'(CNT_MAX)) return CNT_MAX;
    return COUNTER_WIDTH'(sum);
  endfunction

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state                 <= IDLE;
      drain_cnt             <= '0;
      finished              <= 1'b0;
      instRetired           <= '0;
      cycles                <= '0;
      cyclesDecoded         <= '0;
      cyclesEligible        <= '0;
      cyclesIssued          <= '0;
      perWarp_cyclesDecoded <= '0;
      perWarp_stallsWAW     <= '0;
      perWarp_stallsWAR     <= '0;
    end else begin
      case (state)
        IDLE: if (any_active) state <= RUN;
        RUN: begin
          if (!any_active) begin
            state     <= DRAIN;
            drain_cnt <= DCNT_W'(1);
          end
        end
        DRAIN: begin
          if (any_active) begin
            state <= RUN;
          end else if (drain_cnt == DRAIN_LAST) begin
            state    <= DONE;
            finished <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DCNT_W'(1);
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase

      if (count_en) begin
        cycles         <= sat_add(cycles, RETIRE_W'(1'b1));
        instRetired    <= sat_add(instRetired, retireCount);
        cyclesDecoded  <= sat_add(cyclesDecoded, RETIRE_W'(|decodeValid));
        cyclesEligible <= sat_add(cyclesEligible, RETIRE_W'(eligible));
        cyclesIssued   <= sat_add(cyclesIssued, RETIRE_W'(issueFire));
        for (int i = 0; i < NUM_WARPS; i++) begin
          perWarp_cyclesDecoded[i*COUNTER_WIDTH +: COUNTER_WIDTH] <=
            sat_add(perWarp_cyclesDecoded[i*COUNTER_WIDTH +: COUNTER_WIDTH], RETIRE_W'(decodeValid[i]));
          perWarp_stallsWAW[i*COUNTER_WIDTH +: COUNTER_WIDTH] <=
            sat_add(perWarp_stallsWAW[i*COUNTER_WIDTH +: COUNTER_WIDTH], RETIRE_W'(stallWAW[i]));
          perWarp_stallsWAR[i*COUNTER_WIDTH +: COUNTER_WIDTH] <=
            sat_add(perWarp_stallsWAR[i*COUNTER_WIDTH +: COUNTER_WIDTH], RETIRE_W'(stallWAR[i]));
        end
      end
    end
  end

endmodule
